seq_detect_param: RTL and testbench
===================================

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter LEN, default 3, pattern length in bits, legal range 2..32.
REQ-002 Parameter PATTERN, default 3'b101, LEN-bit target; PATTERN[LEN-1] is the first bit received.
REQ-003 Parameter OVERLAP, default 1: 1 = overlapping matches, 0 = non-overlapping.
REQ-004 Parameter CNT_W, default 8, match counter width.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-007 en  input  1  sample qualifier; x is consumed only in cycles with en=1.
REQ-008 x  input  1  serial data bit.
REQ-009 clr  input  1  synchronous clear of history, state and counter.
REQ-010 y  output  1  Mealy match, combinational from state, history, en and x.
REQ-011 y_q  output  1  y registered one clock later.
REQ-012 match_cnt  output  CNT_W  saturating match count.

Function
REQ-013 History register hist holds the last LEN-1 consumed bits; hist[LEN-2] is the oldest; shift on every consumed bit.
REQ-014 Fill counter tracks valid history bits, 0..LEN-1; it increments per consumed bit and saturates at LEN-1.
REQ-015 FSM states: EMPTY (fill=0), FILL (0<fill<LEN-1), ARMED (fill=LEN-1); state is a function of fill.
REQ-016 y=1 iff en=1, state=ARMED, hist equals PATTERN[LEN-1:1] and x equals PATTERN[0]; otherwise y=0.
REQ-017 On a match with OVERLAP=1, hist shifts normally and state stays ARMED.
REQ-018 On a match with OVERLAP=0, fill returns to 0 (EMPTY) and hist content is ignored until refilled.
REQ-019 With en=0, hist, fill, state and match_cnt hold; y=0.
REQ-020 y_q captures y every clock, so the latency from match bit to y_q is 1 clock.
REQ-021 match_cnt increments by 1 on each y=1 cycle and holds at 2^CNT_W-1.
REQ-022 clr=1 forces fill=0, hist=0, match_cnt=0 and y_q=0 next clock, taking priority over en and x.
REQ-023 With clr=1, y is forced to 0 in the same cycle.
REQ-024 For LEN=2, hist is 1 bit wide; no zero-width slices are permitted.

Reset
REQ-025 When rst is low, immediately: fill=0 (EMPTY), hist=0, y_q=0, match_cnt=0; y=0 while rst is low.
REQ-026 Reset asserted mid-sequence discards all partial matches; the first match after release needs LEN fresh consumed bits.

Configuration
REQ-027 Macro SEQDET_COUNT_EN: when defined, match_cnt and its counter are built per REQ-021.
REQ-028 Without SEQDET_COUNT_EN, match_cnt is tied to 0 and no counter flops exist; y and y_q are unchanged.

Structure
REQ-029 Package seq_detect_pkg holds the state enum (EMPTY, FILL, ARMED) and the constant LEN_MAX=32.
REQ-030 The saturating counter is sub-module sat_counter (params W; ports clk, rst, clr, inc, q), instantiated only under SEQDET_COUNT_EN.

Verification
REQ-031 Defaults, en=1, x=1,0,1,0,1 -> y=1 on samples 3 and 5; y_q=1 one clock after each; match_cnt=2.
REQ-032 OVERLAP=0, same stream -> y=1 on sample 3 only; match_cnt=1.
REQ-033 Defaults, x=1,0 with en=1, then en=0 for 4 cycles with x toggling, then x=1 with en=1 -> y=1 only on the final sample.
REQ-034 rst pulsed low after x=1,0, then x=1 -> y=0; a subsequent 1,0,1 gives y=1 on its third bit.
REQ-035 CNT_W=2, 5 matches -> match_cnt saturates at 3; clr=1 together with a matching x -> y=0 and match_cnt=0 next clock.
REQ-036 LEN=4, PATTERN=4'b1101, x=1,1,0,1,1,0,1 -> y=1 on samples 4 and 7 (overlap).

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared types for the serial pattern detector: history-fill state encoding and size limits.
// Imported by seq_detect_param; no logic lives here.
package seq_detect_pkg;

    localparam int LEN_MAX = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: q advances by one per inc cycle and sticks at all-ones; clr wins over inc.
// Result visible one clock after inc; no backpressure.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/seq_detect_param.sv
// Serial LEN-bit pattern detector: Mealy y in the matching bit's cycle, y_q one clock later; en qualifies bits, no backpressure.
// Define SEQDET_COUNT_EN to build the saturating match counter; otherwise match_cnt is tied to zero.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int             LEN     = 3,
    parameter logic [LEN-1:0] PATTERN = 3'b101,
    parameter int             OVERLAP = 1,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic             clr,
    output logic             y,
    output logic             y_q,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int             HW       = LEN - 1;
    localparam int             FW       = $clog2(LEN);
    localparam logic [FW-1:0]  FILL_MAX = FW'(LEN - 1);
    localparam logic [HW-1:0]  PAT_HIST = PATTERN[LEN-1:1];

    state_e        state_q;
    state_e        state_d;
    logic [FW-1:0] fill_q;
    logic [FW-1:0] fill_d;
    logic [HW-1:0] hist_q;
    logic [HW-1:0] hist_d;
    logic          hit;

    // hist_q[0] is the newest bit, hist_q[HW-1] the oldest, so it lines up with PATTERN[LEN-1:1].
    always_comb begin
        hit    = rst && en && !clr && (state_q == ARMED)
                 && (hist_q == PAT_HIST) && (x == PATTERN[0]);
        hist_d = hist_q;
        fill_d = fill_q;
        if (clr) begin
            hist_d = '0;
            fill_d = '0;
        end else if (en) begin
            hist_d = HW'({hist_q, x});
            if (hit && (OVERLAP == 0)) begin
                fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + FW'(1);
            end
        end
        if (fill_d == '0) begin
            state_d = EMPTY;
        end else if (fill_d == FILL_MAX) begin
            state_d = ARMED;
        end else begin
            state_d = FILL;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            fill_q  <= '0;
            hist_q  <= '0;
            y_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            hist_q  <= hist_d;
            y_q     <= hit;
        end
    end

    assign y = hit;

`ifdef SEQDET_COUNT_EN
    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (hit),
        .q   (match_cnt)
    );
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: four configurations share one input stream, driven from a vector table.
// Expected y comes from the table; expected y_q and match_cnt go through a scoreboard queue.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       x   = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] y_w;
    logic [3:0] yq_w;
    logic [7:0] cnt_a;
    logic [7:0] cnt_b;
    logic [1:0] cnt_c;
    logic [7:0] cnt_d;

    always #5 clk = ~clk;

    // 0: defaults (101, overlap)
    seq_detect_param u_a (
        .clk(clk), .rst(rst), .en(en), .x(x), .clr(clr),
        .y(y_w[0]), .y_q(yq_w[0]), .match_cnt(cnt_a)
    );
    // 1: 101, non-overlapping
    seq_detect_param #(.OVERLAP(0)) u_b (
        .clk(clk), .rst(rst), .en(en), .x(x), .clr(clr),
        .y(y_w[1]), .y_q(yq_w[1]), .match_cnt(cnt_b)
    );
    // 2: 101, 2-bit counter
    seq_detect_param #(.CNT_W(2)) u_c (
        .clk(clk), .rst(rst), .en(en), .x(x), .clr(clr),
        .y(y_w[2]), .y_q(yq_w[2]), .match_cnt(cnt_c)
    );
    // 3: 1101, overlap
    seq_detect_param #(.LEN(4), .PATTERN(4'b1101)) u_d (
        .clk(clk), .rst(rst), .en(en), .x(x), .clr(clr),
        .y(y_w[3]), .y_q(yq_w[3]), .match_cnt(cnt_d)
    );

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       x;
        logic       clr;
        logic [3:0] y;     // bit i = expected y of instance i
    } vec_t;

    typedef struct {
        logic [3:0] yq;
        int         cnt [4];
    } exp_t;

    localparam logic [3:0] Y_NONE = 4'b0000;
    localparam logic [3:0] Y_AC   = 4'b0101;
    localparam logic [3:0] Y_ABC  = 4'b0111;
    localparam logic [3:0] Y_ALL  = 4'b1111;

`ifdef SEQDET_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    vec_t vecs [$];
    exp_t sb   [$];
    int   exp_cnt [4] = '{0, 0, 0, 0};
    int   cnt_max [4] = '{255, 255, 3, 255};
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic int act_cnt(input int i);
        case (i)
            0:       return int'(cnt_a);
            1:       return int'(cnt_b);
            2:       return int'(cnt_c);
            default: return int'(cnt_d);
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic rst_n, input logic e, input logic b,
                       input logic c, input logic [3:0] yy);
        vec_t v;
        v.rst_n = rst_n;
        v.en    = e;
        v.x     = b;
        v.clr   = c;
        v.y     = yy;
        vecs.push_back(v);
    endtask

    // Entered at posedge+1; returns at the next posedge+1 after checking registered outputs.
    task automatic apply(input vec_t v, input int k);
        exp_t e;
        exp_t got;
        en  = v.en;
        x   = v.x;
        clr = v.clr;
        if (!v.rst_n) begin
            rst = 1'b0;
            #1;
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("async_rst_yq[%0d] row %0d", i, k), int'(yq_w[i]), 0);
                chk($sformatf("async_rst_cnt[%0d] row %0d", i, k), act_cnt(i), 0);
            end
            rst = 1'b1;
        end
        #2;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("y[%0d] row %0d", i, k), int'(y_w[i]), int'(v.y[i]));
            if (!v.rst_n || v.clr) begin
                exp_cnt[i] = 0;
            end else if (v.y[i] && (exp_cnt[i] < cnt_max[i])) begin
                exp_cnt[i] = exp_cnt[i] + 1;
            end
            e.cnt[i] = CNT_EN ? exp_cnt[i] : 0;
        end
        e.yq = v.y;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("y_q[%0d] row %0d", i, k), int'(yq_w[i]), int'(got.yq[i]));
            chk($sformatf("cnt[%0d] row %0d", i, k), act_cnt(i), got.cnt[i]);
        end
    endtask

    initial begin
        // Stream 1,0,1,0,1: overlap matches on 3 and 5, non-overlap only on 3.
        add(1, 1, 1, 0, Y_NONE);
        add(1, 1, 0, 0, Y_NONE);
        add(1, 1, 1, 0, Y_ABC);
        add(1, 1, 0, 0, Y_NONE);
        add(1, 1, 1, 0, Y_AC);
        add(1, 1, 0, 1, Y_NONE);
        // en=0 gap with x toggling must not disturb history.
        add(1, 1, 1, 0, Y_NONE);
        add(1, 1, 0, 0, Y_NONE);
        add(1, 0, 1, 0, Y_NONE);
        add(1, 0, 0, 0, Y_NONE);
        add(1, 0, 1, 0, Y_NONE);
        add(1, 0, 0, 0, Y_NONE);
        add(1, 1, 1, 0, Y_ABC);
        add(1, 1, 0, 1, Y_NONE);
        // Reset mid-pattern discards 1,0; then 1,1,0,1 matches every configuration.
        add(1, 1, 1, 0, Y_NONE);
        add(1, 1, 0, 0, Y_NONE);
        add(0, 0, 1, 0, Y_NONE);
        add(1, 1, 1, 0, Y_NONE);
        add(1, 1, 1, 0, Y_NONE);
        add(1, 1, 0, 0, Y_NONE);
        add(1, 1, 1, 0, Y_ALL);
        add(1, 1, 0, 1, Y_NONE);
        // 1,1,0,1,1,0,1: matches on 4 and 7 everywhere.
        add(1, 1, 1, 0, Y_NONE);
        add(1, 1, 1, 0, Y_NONE);
        add(1, 1, 0, 0, Y_NONE);
        add(1, 1, 1, 0, Y_ALL);
        add(1, 1, 1, 0, Y_NONE);
        add(1, 1, 0, 0, Y_NONE);
        add(1, 1, 1, 0, Y_ALL);
        add(1, 1, 0, 1, Y_NONE);
        // Eleven alternating bits: five overlap matches saturate the 2-bit counter.
        for (int i = 1; i <= 11; i++) begin
            logic [3:0] yy;
            yy = Y_NONE;
            if ((i % 2 == 1) && (i >= 3)) yy[0] = 1'b1;
            if ((i == 3) || (i == 7) || (i == 11)) yy[1] = 1'b1;
            yy[2] = yy[0];
            add(1, 1, (i % 2 == 1), 0, yy);
        end
        add(1, 1, 0, 0, Y_NONE);
        // clr together with a matching bit suppresses y and zeroes the count.
        add(1, 1, 1, 1, Y_NONE);
        add(1, 0, 0, 0, Y_NONE);

        // Power-on reset: outputs must be zero as soon as rst falls.
        #1 rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset_y[%0d]", i), int'(y_w[i]), 0);
            chk($sformatf("reset_yq[%0d]", i), int'(yq_w[i]), 0);
            chk($sformatf("reset_cnt[%0d]", i), act_cnt(i), 0);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            apply(vecs[k], k);
        end

        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
